// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM bridge: FSM encoding,
// default address map base and the external SRAM data width.
package mem_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned BASE_ADDR_DEF = 32'd1024;
  localparam int unsigned SRAM_DW       = 16;

  // Byte offset into the SRAM window; wraps modulo 2^32 by design.
  function automatic logic [31:0] sram_off(input logic [31:0] byte_addr,
                                           input logic [31:0] base);
    return byte_addr - base;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl.sv
// Bridges a 32-bit pipeline load/store onto a 16-bit asynchronous SRAM as two
// half-word accesses (low half first), holding ready low while busy.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned ACC_CYCLES = 2,
  parameter int unsigned SRAM_AW    = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_dq_oe,
  output logic                sram_we_n,
  inout  wire  [SRAM_DW-1:0]  sram_dq,
  output state_e              dbg_state
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  // Handshake: a request is accepted only in IDLE; ready is high when idle
  // with no request or in DONE, so the pipeline freeze releases exactly once.

  state_e             r_state;
  state_e             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_write;
  logic [SRAM_AW-2:0] r_hw_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;

  logic [31:0]        w_off;
  logic               w_req;
  logic               w_last;
  logic               w_unused_off;

  assign w_off        = sram_off(addr, BASE_ADDR);
  assign w_unused_off = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
  assign w_req        = mem_r_en | mem_w_en;
  assign w_last       = (r_cnt == CW'(ACC_CYCLES - 1));

  assign rdata     = r_rdata;
  assign dbg_state = r_state;
  assign sram_dq   = sram_dq_oe ? sram_dq_out : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_LO || r_state == ST_HI) && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req)  w_next = ST_LO;
      ST_LO:   if (w_last) w_next = ST_HI;
      ST_HI:   if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (r_state)
      ST_IDLE: ready = ~w_req;
      ST_LO: begin
        sram_addr = {r_hw_addr, 1'b0};
        if (r_write) begin
          sram_dq_out = r_wdata[15:0];
          sram_dq_oe  = 1'b1;
          // Strobe rises entering the last cycle so data outlives the edge.
          sram_we_n   = w_last;
        end
      end
      ST_HI: begin
        sram_addr = {r_hw_addr, 1'b1};
        if (r_write) begin
          sram_dq_out = r_wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = w_last;
        end
      end
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Latched request copy; write wins when both enables are set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write   <= 1'b0;
      r_hw_addr <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req) begin
        r_write   <= mem_w_en;
        r_hw_addr <= w_off[SRAM_AW:2];
        r_wdata   <= wdata;
      end
      if (!r_write && w_last) begin
        if (r_state == ST_LO) r_rdata[15:0]  <= sram_dq_in;
        if (r_state == ST_HI) r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural async SRAM model.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  wire  [15:0] sram_dq;
  state_e      dbg_state;

  mem_sram_ctrl dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_dq(sram_dq),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Async SRAM model: write latched on the rising edge of we_n.
  logic [15:0] mem [0:63];
  always @(posedge sram_we_n) mem[sram_addr[5:0]] = sram_dq_out;
  assign sram_dq_in = mem[sram_addr[5:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-access observations
  int          busy_cycles;
  int          we_lo_cnt [2];
  logic [17:0] addr_lo, addr_hi;
  logic [15:0] pad_lo;
  int          done_cyc;

  task automatic drive_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
  endtask

  task automatic drop_req();
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    busy_cycles = 0;
    we_lo_cnt[0] = 0; we_lo_cnt[1] = 0;
    addr_lo = '1; addr_hi = '1; pad_lo = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ready) begin seen = 1; break; end
      busy_cycles++;
      if (!sram_we_n) we_lo_cnt[sram_addr[0]]++;
      if (dbg_state == ST_LO) begin addr_lo = sram_addr; pad_lo = sram_dq; end
      if (dbg_state == ST_HI) addr_hi = sram_addr;
    end
    done_cyc = cyc;
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int first_done;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    #2;
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_dq_out", 32'(sram_dq_out), 32'h0);
    check("rst_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    #21 rst = 1'b1;

    // Idle without request
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'h1);
      check("idle_we_n", 32'(sram_we_n), 32'h1);
      check("idle_oe", 32'(sram_dq_oe), 32'h0);
    end

    // Store 1024 <- DEADBEEF
    drive_req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    wait_done();
    check("st0_busy", 32'(busy_cycles), 32'd5);
    check("st0_we_lo", 32'(we_lo_cnt[0]), 32'd1);
    check("st0_we_hi", 32'(we_lo_cnt[1]), 32'd1);
    check("st0_pad_lo", 32'(pad_lo), 32'h0000BEEF);
    check("st0_rdata", rdata, 32'h0);
    drop_req();
    check("st0_mem0", 32'(mem[0]), 32'h0000BEEF);
    check("st0_mem1", 32'(mem[1]), 32'h0000DEAD);

    // Load 1024
    drive_req(1'b1, 1'b0, 32'd1024, 32'h0);
    wait_done();
    check("ld0_busy", 32'(busy_cycles), 32'd5);
    check("ld0_we", 32'(we_lo_cnt[0] + we_lo_cnt[1]), 32'd0);
    check("ld0_rdata", rdata, 32'hDEADBEEF);
    drop_req();

    // Store 1032 then load 1032 back-to-back
    drive_req(1'b0, 1'b1, 32'd1032, 32'h12345678);
    wait_done();
    first_done = done_cyc;
    check("st1_addr_lo", 32'(addr_lo), 32'd4);
    check("st1_addr_hi", 32'(addr_hi), 32'd5);
    check("st1_rdata", rdata, 32'hDEADBEEF);
    drive_req(1'b1, 1'b0, 32'd1032, 32'h0);
    wait_done();
    check("b2b_gap", 32'(done_cyc - first_done), 32'd6);
    check("b2b_addr_lo", 32'(addr_lo), 32'd4);
    check("b2b_rdata", rdata, 32'h12345678);
    drop_req();
    check("st1_mem4", 32'(mem[4]), 32'h00005678);
    check("st1_mem5", 32'(mem[5]), 32'h00001234);

    // Both enables: write wins
    drive_req(1'b1, 1'b1, 32'd1040, 32'hA5A55A5A);
    wait_done();
    check("both_we_lo", 32'(we_lo_cnt[0]), 32'd1);
    check("both_rdata", rdata, 32'h12345678);
    drop_req();
    check("both_mem8", 32'(mem[8]), 32'h00005A5A);
    check("both_mem9", 32'(mem[9]), 32'h0000A5A5);

    // Reset during HI phase of a store
    drive_req(1'b0, 1'b1, 32'd1048, 32'h13572468);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dbg_state == ST_HI) break;
    end
    check("rst_mid_state", 32'(dbg_state), 32'(ST_HI));
    check("rst_mid_we_pre", 32'(sram_we_n), 32'h0);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_we_n", 32'(sram_we_n), 32'h1);
    check("rst_mid_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_mid_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_mid_rdata", rdata, 32'h0);
    check("rst_mid_mem12", 32'(mem[12]), 32'h00002468);
    mem_w_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'h1);
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage consumer of the EXE stage's memory outputs: ALU result as byte address, Rm value as store data, plus memory read/write enables.
- Bridges the 32-bit pipeline word to an external 16-bit asynchronous SRAM as two half-word accesses (low half first).
- Drives `ready` low while an access is in flight; the hazard/freeze logic stalls all pipeline registers while `ready` is 0.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- ACC_CYCLES, 2: cycles each half-word access is held on the SRAM pins (>=1).
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request from EXE/MEM register.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (forwarded Rm value).
- rdata  out  32  load result to MEM/WB register.
- ready  out  1  1 = no access pending or access completing this cycle.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to pad.
- sram_dq_in  in  16  read data from pad.
- sram_dq_oe  out  1  pad output enable (1 = drive).
- sram_we_n  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset values: state IDLE, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, wait counter=0. `ready` follows its combinational rule.
- Address mapping: off = addr - BASE_ADDR (32-bit wrap). sram_addr = {off[SRAM_AW:2], half}, where half=0 is the low word half and half=1 is the high half. off[1:0] is ignored. Out-of-range addresses wrap silently.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(mem_r_en | mem_w_en).
  - On a request, latch op, address and wdata; go to LO.
  - If mem_r_en and mem_w_en are both 1, perform a write.
- LO: held for ACC_CYCLES cycles (counter counts 0..ACC_CYCLES-1).
  - sram_addr uses half=0.
  - Write: sram_dq_out = wdata[15:0], sram_dq_oe=1, sram_we_n=0 on all phase cycles except the last; sram_we_n=1 on the last cycle so data holds past the strobe edge.
  - Read: sram_dq_oe=0, sram_we_n=1; on the last cycle capture sram_dq_in into rdata[15:0].
  - Then go to HI with the counter cleared.
- HI: same as LO with half=1 and data bits [31:16]; then go to DONE.
- DONE: one cycle with ready=1 and SRAM pins idle (oe=0, we_n=1); then go to IDLE unconditionally.
- Latency: request first seen in IDLE at cycle 0; ready=0 in cycles 0..2*ACC_CYCLES; ready=1 at cycle 2*ACC_CYCLES+1 (cycle 5 at default).
- rdata: valid from the DONE cycle; held until the next read overwrites it (writes do not alter it). The low half updates one phase before the high half; consumers sample only at DONE.
- Request inputs may change while busy; they are ignored because the latched copy is used. The pipeline freeze normally holds them stable.
- Back-to-back: the request present in IDLE right after DONE belongs to the next instruction and starts a new access.
- Reset asserted mid-access: immediately go to IDLE, sram_we_n=1, sram_dq_oe=0. A partial write is permitted to leave one half updated.
- ready is never 0 in IDLE without a request. ready never stays 0 longer than 2*ACC_CYCLES+1 cycles per request.

Decomposition:
- Shared package: state encoding (IDLE/LO/HI/DONE), BASE_ADDR default, the SRAM data width of 16.
- No sub-module. The phase counter and FSM are inline.
- The top level owns the tri-state pad: inout = sram_dq_oe ? sram_dq_out : 'z.

Test Plan:
- No request (mem_r_en=mem_w_en=0) for 10 cycles -> ready=1 throughout, sram_we_n=1, sram_dq_oe=0.
- Store addr=1024, wdata=0xDEADBEEF -> SRAM model gets half-word 0 = 0xBEEF and half-word 1 = 0xDEAD; ready=0 in cycles 0-4 and 1 in cycle 5; each phase shows exactly one sram_we_n low cycle.
- Load addr=1024 after the above -> rdata=0xDEADBEEF at the DONE cycle; rdata unchanged after a subsequent store to 1032.
- Store addr=1032, wdata=0x12345678, then load 1032 back-to-back (request held in IDLE right after DONE) -> sram_addr 4 then 5, rdata=0x12345678, second ready pulse 6 cycles after the first.
- mem_r_en=mem_w_en=1, addr=1040, wdata=0xA5A55A5A -> write performed (half-words 8/9 = 0x5A5A/0xA5A5), rdata unchanged.
- rst=0 asserted during the HI phase of a store -> same cycle sram_we_n=1, sram_dq_oe=0; state IDLE, rdata=0; after release with no request, ready=1.
